// File: rtl/muldiv_pkg.sv
// Shared types and helpers for the HI/LO multiply/divide unit.
// Latency: none (declarations only).
// Backpressure: not applicable.
package muldiv_pkg;

   // Widest operand the helpers below are able to handle
   localparam int ABS_MAX_W = 64;

   typedef enum logic [1:0] {
      OP_MULT  = 2'b00,
      OP_MULTU = 2'b01,
      OP_DIV   = 2'b10,
      OP_DIVU  = 2'b11
   } op_t;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_FIX  = 2'd2
   } state_t;

   // Quotient reported for a zero divisor; callers truncate it to their width
   localparam logic [ABS_MAX_W-1:0] DIV0_QUOT = '1;

   // Magnitude of a w-bit two's complement value held in the low bits of v.
   // The most negative value maps to itself, which reads correctly as unsigned.
   function automatic logic [ABS_MAX_W-1:0] abs_val(input logic [ABS_MAX_W-1:0] v,
                                                     input int unsigned         w);
      logic [ABS_MAX_W-1:0] sign_mask;
      logic [ABS_MAX_W-1:0] r;
      sign_mask = {{(ABS_MAX_W-1){1'b0}}, 1'b1} << (w - 1);
      r = v;
      if ((v & sign_mask) != '0) begin
         r = ~v + 1'b1;
      end
      return r;
   endfunction

endpackage

// File: rtl/muldiv_if.sv
// EX-stage <-> multiply/divide unit signal bundle.
// Latency: none (wiring only).
// Backpressure: stall from the unit holds FETCH/EX while an op is in flight.
interface muldiv_if #(
   parameter int WIDTH = 32
) ();
   import muldiv_pkg::*;

   // requests from EX
   logic             start;
   op_t              op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             hilo_rd;
   logic             mthi;
   logic             mtlo;
   logic [WIDTH-1:0] wdata;

   // status and HI/LO back to the pipeline
   logic             stall;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (
      output start, op, a, b, hilo_rd, mthi, mtlo, wdata,
      input  stall, busy, done, hi, lo
   );

   modport slave (
      input  start, op, a, b, hilo_rd, mthi, mtlo, wdata,
      output stall, busy, done, hi, lo
   );

endinterface

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add for multiply, restoring subtract for divide.
// Latency: purely combinational.
// Backpressure: none; the sequencer decides when the result is registered.
module muldiv_step #(
   parameter int WIDTH = 32
) (
   input  logic             is_div_i,
   input  logic [WIDTH-1:0] acc_i,   // product high half / partial remainder
   input  logic [WIDTH-1:0] lo_i,    // multiplier bits / dividend-quotient shift reg
   input  logic [WIDTH-1:0] opd_i,   // multiplicand / divisor
   output logic [WIDTH-1:0] acc_o,
   output logic [WIDTH-1:0] lo_o
);

   logic [WIDTH:0]   sum;     // acc + multiplicand with carry-out
   logic [WIDTH:0]   shl;     // remainder shifted left with next dividend bit
   logic [WIDTH-1:0] sub_lo;  // low bits of shl - divisor (exact when it fits)
   logic             ge;      // divisor fits in the shifted remainder

   // Both candidate steps are formed every cycle; is_div_i picks one
   always_comb begin
      sum    = {1'b0, acc_i} + (lo_i[0] ? {1'b0, opd_i} : {(WIDTH+1){1'b0}});
      shl    = {acc_i, lo_i[WIDTH-1]};
      ge     = (shl >= {1'b0, opd_i});
      sub_lo = shl[WIDTH-1:0] - opd_i;
      acc_o  = sum[WIDTH:1];
      lo_o   = {sum[0], lo_i[WIDTH-1:1]};
      if (is_div_i) begin
         if (ge) begin
            acc_o = sub_lo;
            lo_o  = {lo_i[WIDTH-2:0], 1'b1};
         end else begin
            acc_o = shl[WIDTH-1:0];
            lo_o  = {lo_i[WIDTH-2:0], 1'b0};
         end
      end
   end

endmodule

// File: rtl/muldiv_sequencer.sv
// HI/LO owner: iterates MULT/MULTU/DIV/DIVU one bit per cycle, serves MTHI/MTLO.
// Latency: start at edge N -> done and bypassed HI/LO in cycle N+WIDTH+1.
// Backpressure: stall while RUN if EX needs HI/LO or the unit; a start is taken in IDLE or the done cycle.
module muldiv_sequencer
   import muldiv_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6    // 2**CNT_W must exceed WIDTH
) (
   input  logic     clk,
   input  logic     rst,
   muldiv_if.slave  bus
);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   op_t              op_q, op_d;
   logic             neg_lo_q, neg_lo_d;   // negate product / quotient
   logic             neg_hi_q, neg_hi_d;   // negate remainder (dividend sign)
   logic             div0_q, div0_d;       // divisor was zero
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] wlo_q, wlo_d;
   logic [WIDTH-1:0] opd_q, opd_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;

   logic             is_div;
   logic             in_signed;
   logic             accept;
   logic [WIDTH-1:0] a_mag, b_mag;
   logic [WIDTH-1:0] step_acc, step_lo;
   logic [WIDTH-1:0] hi_res, lo_res;
   logic [2*WIDTH-1:0] prod, prod_fix;
   logic [WIDTH-1:0] quot, rem;

   assign is_div = (op_q == OP_DIV) || (op_q == OP_DIVU);

   muldiv_step #(.WIDTH(WIDTH)) u_step (
      .is_div_i (is_div),
      .acc_i    (acc_q),
      .lo_i     (wlo_q),
      .opd_i    (opd_q),
      .acc_o    (step_acc),
      .lo_o     (step_lo)
   );

   // Operand conditioning: signed ops iterate on magnitudes, sign fixed up at the end
   always_comb begin
      in_signed = (bus.op == OP_MULT) || (bus.op == OP_DIV);
      a_mag     = bus.a;
      b_mag     = bus.b;
      if (in_signed) begin
         a_mag = WIDTH'(abs_val(ABS_MAX_W'(bus.a), WIDTH));
         b_mag = WIDTH'(abs_val(ABS_MAX_W'(bus.b), WIDTH));
      end
   end

   // Final sign correction; valid while in S_FIX and bypassed onto hi/lo there
   always_comb begin
      prod     = {acc_q, wlo_q};
      prod_fix = neg_lo_q ? -prod : prod;
      quot     = neg_lo_q ? -wlo_q : wlo_q;
      rem      = neg_hi_q ? -acc_q : acc_q;
      hi_res   = prod_fix[2*WIDTH-1:WIDTH];
      lo_res   = prod_fix[WIDTH-1:0];
      if (is_div) begin
         hi_res = rem;
         lo_res = div0_q ? WIDTH'(DIV0_QUOT) : quot;
      end
   end

   // Next-state: FSM, iteration counter, working registers and HI/LO writes
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      op_d     = op_q;
      neg_lo_d = neg_lo_q;
      neg_hi_d = neg_hi_q;
      div0_d   = div0_q;
      acc_d    = acc_q;
      wlo_d    = wlo_q;
      opd_d    = opd_q;
      hi_d     = hi_q;
      lo_d     = lo_q;

      // The done cycle accepts a new op so back-to-back issue has no bubble
      accept = bus.start && (state_q != S_RUN);

      case (state_q)
         S_IDLE: begin
            state_d = S_IDLE;
         end
         S_RUN: begin
            acc_d = step_acc;
            wlo_d = step_lo;
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CNT_W'(1)) begin
               state_d = S_FIX;
            end
         end
         S_FIX: begin
            hi_d    = hi_res;
            lo_d    = lo_res;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (accept) begin
         state_d  = S_RUN;
         cnt_d    = CNT_W'(WIDTH);
         op_d     = bus.op;
         acc_d    = '0;
         wlo_d    = a_mag;
         opd_d    = b_mag;
         neg_lo_d = in_signed && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
         neg_hi_d = in_signed && bus.a[WIDTH-1];
         div0_d   = (bus.b == '0);
      end else if (state_q != S_RUN) begin
         // MTHI/MTLO follow the mul/div in program order, so they override a result
         // committed in the same cycle; a simultaneous start drops them entirely.
         if (bus.mthi) begin
            hi_d = bus.wdata;
         end
         if (bus.mtlo) begin
            lo_d = bus.wdata;
         end
      end
   end

   // State and datapath registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         op_q     <= OP_MULT;
         neg_lo_q <= 1'b0;
         neg_hi_q <= 1'b0;
         div0_q   <= 1'b0;
         acc_q    <= '0;
         wlo_q    <= '0;
         opd_q    <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         op_q     <= op_d;
         neg_lo_q <= neg_lo_d;
         neg_hi_q <= neg_hi_d;
         div0_q   <= div0_d;
         acc_q    <= acc_d;
         wlo_q    <= wlo_d;
         opd_q    <= opd_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
      end
   end

   assign bus.busy  = (state_q != S_IDLE);
   assign bus.done  = (state_q == S_FIX);
   assign bus.stall = (state_q == S_RUN) &&
                      (bus.start || bus.hilo_rd || bus.mthi || bus.mtlo);
   assign bus.hi    = (state_q == S_FIX) ? hi_res : hi_q;
   assign bus.lo    = (state_q == S_FIX) ? lo_res : lo_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Bench for muldiv_sequencer: vector table, random ops against a behavioural model, corner sequences.
// Latency: every op is expected to report done 33 cycles after its accepting edge.
// Backpressure: stall is checked while an op is in flight and HI/LO are requested.
module tb_muldiv_sequencer;
   import muldiv_pkg::*;

   localparam int W = 32;

   typedef struct {
      op_t         op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp_hi;
      logic [31:0] exp_lo;
   } vec_t;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
   } res_t;

   logic clk = 1'b0;
   logic rst;
   int   n_vec = 0;
   int   n_err = 0;
   res_t sb[$];

   always #5 clk = ~clk;

   muldiv_if #(.WIDTH(W)) bus ();

   muldiv_sequencer #(.WIDTH(W), .CNT_W(6)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, want 0x%08h", nm, act, exp);
      end
   endtask

   // Reference: returns {hi, lo}
   function automatic logic [63:0] model(input op_t op, input logic [31:0] a, input logic [31:0] b);
      logic signed [63:0] sp;
      logic signed [31:0] sq;
      logic signed [31:0] sr;
      case (op)
         OP_MULT: begin
            sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
            return sp;
         end
         OP_MULTU: return {32'd0, a} * {32'd0, b};
         OP_DIV: begin
            if (b == 32'd0) return {a, 32'hFFFFFFFF};
            if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'd0, 32'h80000000};
            sq = $signed(a) / $signed(b);
            sr = $signed(a) % $signed(b);
            return {sr, sq};
         end
         default: begin
            if (b == 32'd0) return {a, 32'hFFFFFFFF};
            return {a % b, a / b};
         end
      endcase
   endfunction

   // Present a start for one edge and record the expected result
   task automatic issue(input op_t op, input logic [31:0] a, input logic [31:0] b, input res_t exp);
      bus.op    = op;
      bus.a     = a;
      bus.b     = b;
      bus.start = 1'b1;
      sb.push_back(exp);
      @(posedge clk);
      #1;
      bus.start = 1'b0;
   endtask

   // Wait (bounded) for done, check latency and the bypassed HI/LO; returns at the done-cycle negedge
   task automatic finish_op(input string nm, input int skip);
      int   cyc;
      res_t e;
      cyc = 0;
      for (int i = 1 + skip; i <= 45; i++) begin
         @(negedge clk);
         if (bus.done === 1'b1) begin
            cyc = i;
            break;
         end
      end
      chk({nm, " latency"}, 32'(cyc), 32'd33);
      if (sb.size() == 0) begin
         n_vec++;
         n_err++;
         $display("FAIL %s scoreboard: got empty queue, want one entry", nm);
      end else begin
         e = sb.pop_front();
         chk({nm, " hi"}, bus.hi, e.hi);
         chk({nm, " lo"}, bus.lo, e.lo);
      end
   endtask

   initial begin
      vec_t        vt[12];
      logic [63:0] m;
      op_t         rop;
      logic [31:0] ra, rb;
      int          stall_miss;
      int          done_cnt;
      int          cyc;
      res_t        e;

      vt[0]  = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
      vt[1]  = '{OP_MULT,  32'hFFFFFFF9, 32'h00000006, 32'hFFFFFFFF, 32'hFFFFFFD6};
      vt[2]  = '{OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
      vt[3]  = '{OP_DIVU,  32'h00000064, 32'h00000000, 32'h00000064, 32'hFFFFFFFF};
      vt[4]  = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
      vt[5]  = '{OP_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
      vt[6]  = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
      vt[7]  = '{OP_DIV,   32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, 32'hFFFFFFFF};
      vt[8]  = '{OP_MULTU, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000};
      vt[9]  = '{OP_DIVU,  32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF};
      vt[10] = '{OP_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
      vt[11] = '{OP_DIV,   32'hFFFFFF9C, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'h0000000E};

      rst         = 1'b1;
      bus.start   = 1'b0;
      bus.op      = OP_MULT;
      bus.a       = '0;
      bus.b       = '0;
      bus.hilo_rd = 1'b0;
      bus.mthi    = 1'b0;
      bus.mtlo    = 1'b0;
      bus.wdata   = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // reset state
      @(negedge clk);
      chk("reset hi", bus.hi, 32'd0);
      chk("reset lo", bus.lo, 32'd0);
      chk("reset busy", 32'(bus.busy), 32'd0);
      chk("reset done", 32'(bus.done), 32'd0);
      chk("reset stall", 32'(bus.stall), 32'd0);

      // MTHI while idle lands on the next cycle, then MTLO
      @(posedge clk);
      #1;
      bus.mthi  = 1'b1;
      bus.wdata = 32'h00001234;
      @(negedge clk);
      chk("mthi same cycle hi", bus.hi, 32'd0);
      @(posedge clk);
      #1;
      bus.mthi  = 1'b0;
      bus.mtlo  = 1'b1;
      bus.wdata = 32'h0000ABCD;
      @(negedge clk);
      chk("mthi next cycle hi", bus.hi, 32'h00001234);
      @(posedge clk);
      #1;
      bus.mtlo = 1'b0;
      @(negedge clk);
      chk("mtlo lo", bus.lo, 32'h0000ABCD);
      chk("mtlo keeps hi", bus.hi, 32'h00001234);

      // start together with mthi: start wins, the write is dropped
      bus.mthi  = 1'b1;
      bus.wdata = 32'h0000DEAD;
      issue(OP_MULTU, 32'd2, 32'd3, '{32'd0, 32'd6});
      bus.mthi = 1'b0;
      @(negedge clk);
      chk("start beats mthi hi", bus.hi, 32'h00001234);
      chk("start beats mthi busy", 32'(bus.busy), 32'd1);
      finish_op("mul 2x3", 1);
      @(negedge clk);
      chk("mul 2x3 busy after", 32'(bus.busy), 32'd0);

      // directed vector table
      for (int i = 0; i < 12; i++) begin
         issue(vt[i].op, vt[i].a, vt[i].b, '{vt[i].exp_hi, vt[i].exp_lo});
         finish_op($sformatf("vec%0d", i), 0);
         @(negedge clk);
         chk($sformatf("vec%0d busy after", i), 32'(bus.busy), 32'd0);
      end

      // stall while HI/LO are requested mid-op, released in the done cycle
      issue(OP_MULTU, 32'd3, 32'd5, '{32'd0, 32'd15});
      @(negedge clk);
      chk("stall no request", 32'(bus.stall), 32'd0);
      @(posedge clk);
      #1 bus.hilo_rd = 1'b1;
      stall_miss = 0;
      cyc = 0;
      for (int i = 2; i <= 45; i++) begin
         @(negedge clk);
         if (bus.done === 1'b1) begin
            cyc = i;
            break;
         end
         if (bus.stall !== 1'b1) stall_miss++;
      end
      chk("stall held cycles missing", 32'(stall_miss), 32'd0);
      chk("stall op latency", 32'(cyc), 32'd33);
      chk("stall done-cycle stall", 32'(bus.stall), 32'd0);
      chk("stall done-cycle lo", bus.lo, 32'd15);
      e = sb.pop_front();
      chk("stall done-cycle hi", bus.hi, e.hi);
      bus.hilo_rd = 1'b0;
      @(negedge clk);

      // back-to-back: DIVU issued in the MULTU done cycle
      issue(OP_MULTU, 32'd6, 32'd7, '{32'd0, 32'd42});
      finish_op("b2b mul", 0);
      issue(OP_DIVU, 32'd20, 32'd3, '{32'd2, 32'd6});
      finish_op("b2b div", 0);
      @(negedge clk);

      // random ops against the model
      for (int i = 0; i < 16; i++) begin
         rop = op_t'($urandom_range(0, 3));
         ra  = $urandom;
         rb  = $urandom;
         if ($urandom_range(0, 3) == 0) rb = $urandom_range(0, 5);
         m = model(rop, ra, rb);
         issue(rop, ra, rb, '{m[63:32], m[31:0]});
         finish_op($sformatf("rnd%0d", i), 0);
         @(negedge clk);
      end

      // reset in the middle of a DIV discards it
      issue(OP_MULTU, 32'h00010001, 32'h00010001, '{32'h00000001, 32'h00020001});
      finish_op("pre-reset mul", 0);
      @(negedge clk);
      issue(OP_DIV, 32'd100, 32'd7, '{32'd2, 32'd14});
      void'(sb.pop_back());
      repeat (9) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("mid-op reset busy", 32'(bus.busy), 32'd0);
      chk("mid-op reset hi", bus.hi, 32'd0);
      chk("mid-op reset lo", bus.lo, 32'd0);
      done_cnt = 0;
      repeat (40) begin
         @(negedge clk);
         if (bus.done === 1'b1) done_cnt++;
      end
      chk("mid-op reset done pulses", 32'(done_cnt), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
